// File: rtl/atm_pkg.sv
// Shared constants for the ATM PIN-entry block: FSM state codes and BCD/PIN widths.
package atm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam int DIGIT_W       = 4;
  localparam int PIN_W         = 16;
  localparam int DEF_MAX_TRIES = 3;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// Loadable down-counter that flags when a COLLECT session has sat idle for TIMEOUT_CYC cycles.
module atm_idle_timer #(
  parameter int TIMEOUT_CYC = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart)
      cnt <= TW'(TIMEOUT_CYC);
    else if (run && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  // Expiry is flagged on the idle cycle that would take the count from 1 to 0.
  assign expired = run && (cnt == TW'(1));

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad PIN assembly and verification with attempt counting, lockout and idle timeout.
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      session_start,
  input  logic                      key_valid,
  input  logic [DIGIT_W-1:0]        key_digit,
  input  logic                      key_clear,
  input  logic                      key_enter,
  input  logic [DIGIT_W*DIGITS-1:0] stored_pin,
  output logic [DIGIT_W*DIGITS-1:0] pin_input,
  output logic                      correct_pin,
  output logic                      wrong_pin,
  output logic                      timeout,
  output logic [1:0]                attempts,
  output logic                      lockout,
  output logic                      busy
);

  localparam int PW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] count;
  logic          in_collect;
  logic          accept;
  logic          activity;
  logic          restart;
  logic          run;
  logic          expired;
  logic          check_pass;
  logic          last_try;

  always_comb begin
    in_collect = (state == ST_COLLECT);
    accept     = in_collect && key_valid && !session_start && !key_clear && !key_enter &&
                 is_bcd(key_digit) && (count < CW'(DIGITS));
    activity   = in_collect && (session_start || key_clear || key_enter || accept);
    restart    = !in_collect || activity;
    run        = in_collect && !activity;
    check_pass = (count == CW'(DIGITS)) && (pin_input == stored_pin);
    last_try   = (int'(attempts) + 1) >= MAX_TRIES;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (session_start) state_next = ST_COLLECT;
      ST_COLLECT: begin
        if (session_start || key_clear || accept) state_next = ST_COLLECT;
        else if (key_enter)                        state_next = ST_CHECK;
        else if (expired)                          state_next = ST_IDLE;
      end
      ST_CHECK:   state_next = check_pass ? ST_IDLE : (last_try ? ST_LOCKED : ST_COLLECT);
      default:    state_next = ST_LOCKED;
    endcase
  end

  atm_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .run    (run),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pin_input   <= '0;
      count       <= '0;
      attempts    <= '0;
      correct_pin <= 1'b0;
      wrong_pin   <= 1'b0;
      timeout     <= 1'b0;
      lockout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next == ST_COLLECT) || (state_next == ST_CHECK);
      correct_pin <= 1'b0;
      wrong_pin   <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (session_start) begin
            attempts  <= '0;
            count     <= '0;
            pin_input <= '0;
          end
        end
        ST_COLLECT: begin
          if (session_start) begin
            attempts  <= '0;
            count     <= '0;
            pin_input <= '0;
          end else if (key_clear) begin
            count     <= '0;
            pin_input <= '0;
          end else if (accept) begin
            // The first digit of an attempt replaces whatever the previous check left behind.
            if (count == '0)
              pin_input <= {{(PW-DIGIT_W){1'b0}}, key_digit};
            else
              pin_input <= {pin_input[PW-DIGIT_W-1:0], key_digit};
            count <= count + 1'b1;
          end else if (!key_enter && expired) begin
            timeout <= 1'b1;
          end
        end
        ST_CHECK: begin
          count <= '0;
          if (check_pass) begin
            correct_pin <= 1'b1;
          end else begin
            wrong_pin <= 1'b1;
            attempts  <= attempts + 2'd1;
            if (last_try) lockout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: fixed vector table, hand-written corner sequences, random run vs. reference model.
module tb_atm_pin_entry;

  localparam int DIGITS  = 4;
  localparam int MAXT    = 3;
  localparam int TMO     = 30;

  logic        clk = 1'b0;
  logic        reset, session_start, key_valid, key_clear, key_enter;
  logic [3:0]  key_digit;
  logic [15:0] stored_pin;
  logic [15:0] pin_input;
  logic        correct_pin, wrong_pin, timeout, lockout, busy;
  logic [1:0]  attempts;

  int total = 0;
  int bad   = 0;

  atm_pin_entry #(.DIGITS(DIGITS), .MAX_TRIES(MAXT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .session_start(session_start), .key_valid(key_valid),
    .key_digit(key_digit), .key_clear(key_clear), .key_enter(key_enter),
    .stored_pin(stored_pin), .pin_input(pin_input), .correct_pin(correct_pin),
    .wrong_pin(wrong_pin), .timeout(timeout), .attempts(attempts), .lockout(lockout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ss, kv, clr, ent;
    logic [3:0] kd;
    logic [15:0] pin;
    logic cp, wp, to, lk, bz;
    logic [1:0] att;
  } vec_t;

  vec_t vt[$];

  // Reference model: session flags, a queue of accepted digits and a plain idle-cycle tally.
  bit m_sess, m_chk, m_lock;
  int m_digs[$];
  int m_shown, m_tries, m_idle;
  bit m_cp, m_wp, m_to;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit ss, input bit kv, input int kd,
                            input bit clr, input bit ent);
    m_cp = 0; m_wp = 0; m_to = 0;
    if (rst) begin
      m_sess = 0; m_chk = 0; m_lock = 0; m_digs.delete();
      m_shown = 0; m_tries = 0; m_idle = 0;
    end else if (m_lock) begin
    end else if (m_chk) begin
      m_chk = 0;
      if (m_digs.size() == DIGITS && m_shown == int'(stored_pin)) begin
        m_cp = 1; m_sess = 0;
      end else begin
        m_wp = 1; m_tries++;
        if (m_tries == MAXT) begin m_lock = 1; m_sess = 0; end
      end
      m_digs.delete(); m_idle = 0;
    end else if (m_sess) begin
      if (ss) begin
        m_tries = 0; m_digs.delete(); m_shown = 0; m_idle = 0;
      end else if (clr) begin
        m_digs.delete(); m_shown = 0; m_idle = 0;
      end else if (ent) begin
        m_chk = 1; m_idle = 0;
      end else if (kv && kd <= 9 && m_digs.size() < DIGITS) begin
        m_digs.push_back(kd);
        m_shown = 0;
        foreach (m_digs[i]) m_shown = m_shown * 16 + m_digs[i];
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_to = 1; m_sess = 0; end
      end
    end else if (ss) begin
      m_sess = 1; m_tries = 0; m_digs.delete(); m_shown = 0; m_idle = 0;
    end
  endtask

  task automatic compare_model();
    check("pin_input",   pin_input,          16'(m_shown));
    check("correct_pin", {15'd0, correct_pin}, {15'd0, m_cp});
    check("wrong_pin",   {15'd0, wrong_pin},   {15'd0, m_wp});
    check("timeout",     {15'd0, timeout},     {15'd0, m_to});
    check("attempts",    {14'd0, attempts},    16'(m_tries));
    check("lockout",     {15'd0, lockout},     {15'd0, m_lock});
    check("busy",        {15'd0, busy},        {15'd0, m_sess || m_chk});
  endtask

  task automatic cyc(input bit rst, input bit ss, input bit kv, input int kd,
                     input bit clr, input bit ent);
    reset = rst; session_start = ss; key_valid = kv; key_digit = 4'(kd);
    key_clear = clr; key_enter = ent;
    model_step(rst, ss, kv, kd, clr, ent);
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic idle1(); cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic key(input int d); cyc(0, 0, 1, d, 0, 0); endtask

  task automatic add(input logic rst, ss, kv, input logic [3:0] kd, input logic clr, ent,
                     input logic [15:0] pin, input logic cp, wp, to,
                     input logic [1:0] att, input logic lk, bz);
    vec_t v;
    v.rst = rst; v.ss = ss; v.kv = kv; v.kd = kd; v.clr = clr; v.ent = ent;
    v.pin = pin; v.cp = cp; v.wp = wp; v.to = to; v.att = att; v.lk = lk; v.bz = bz;
    vt.push_back(v);
  endtask

  initial begin
    reset = 1; session_start = 0; key_valid = 0; key_digit = 0;
    key_clear = 0; key_enter = 0; stored_pin = 16'h1234;
    m_sess = 0; m_chk = 0; m_lock = 0; m_shown = 0; m_tries = 0; m_idle = 0;

    //   rst ss kv kd clr ent   pin      cp wp to att lk bz
    add(1, 0, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h2, 0, 0, 16'h0012, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'hA, 0, 0, 16'h0012, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h3, 0, 0, 16'h0123, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h4, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h5, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 1, 16'h1234, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h9, 0, 0, 16'h0009, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h2, 0, 0, 16'h0012, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 1, 16'h0012, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 0, 16'h0012, 0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'h7, 0, 0, 16'h0007, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 4'h5, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h5, 0, 0, 16'h0005, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);

    foreach (vt[i]) begin
      reset = vt[i].rst; session_start = vt[i].ss; key_valid = vt[i].kv;
      key_digit = vt[i].kd; key_clear = vt[i].clr; key_enter = vt[i].ent;
      @(posedge clk); #1;
      check($sformatf("vec%0d.pin", i),      pin_input,            vt[i].pin);
      check($sformatf("vec%0d.correct", i),  {15'd0, correct_pin}, {15'd0, vt[i].cp});
      check($sformatf("vec%0d.wrong", i),    {15'd0, wrong_pin},   {15'd0, vt[i].wp});
      check($sformatf("vec%0d.timeout", i),  {15'd0, timeout},     {15'd0, vt[i].to});
      check($sformatf("vec%0d.attempts", i), {14'd0, attempts},    {14'd0, vt[i].att});
      check($sformatf("vec%0d.lockout", i),  {15'd0, lockout},     {15'd0, vt[i].lk});
      check($sformatf("vec%0d.busy", i),     {15'd0, busy},        {15'd0, vt[i].bz});
    end

    // Lockout after three all-zero entries; a later correct session is ignored.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int t = 1; t <= 3; t++) begin
      for (int d = 0; d < 4; d++) key(0);
      cyc(0, 0, 0, 0, 0, 1);
      idle1();
      check("lock.wrong_pulse", {15'd0, wrong_pin}, 16'd1);
      check("lock.attempts",    {14'd0, attempts},  16'(t));
      check("lock.lockout",     {15'd0, lockout},   {15'd0, t == 3});
    end
    cyc(0, 1, 0, 0, 0, 0);
    key(1); key(2); key(3); key(4);
    cyc(0, 0, 0, 0, 0, 1);
    idle1(); idle1();
    check("lock.absorb_cp",   {15'd0, correct_pin}, 16'd0);
    check("lock.absorb_lock", {15'd0, lockout},     16'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("lock.reset_clears", {15'd0, lockout}, 16'd0);

    // Short entry, then a full correct one.
    cyc(0, 1, 0, 0, 0, 0);
    key(1); key(2);
    cyc(0, 0, 0, 0, 0, 1);
    idle1();
    check("short.wrong", {15'd0, wrong_pin}, 16'd1);
    check("short.busy",  {15'd0, busy},      16'd1);
    key(1); key(2); key(3); key(4);
    cyc(0, 0, 0, 0, 0, 1);
    idle1();
    check("short.then_correct", {15'd0, correct_pin}, 16'd1);

    // Timeout after exactly TMO idle cycles following the last accepted digit.
    cyc(0, 1, 0, 0, 0, 0);
    key(1);
    for (int i = 0; i < TMO; i++) begin
      if (i == TMO - 2) key(12); else idle1();
      check($sformatf("tmo.cycle%0d", i), {15'd0, timeout}, {15'd0, i == TMO - 1});
    end
    check("tmo.idle", {15'd0, busy}, 16'd0);

    // Reset mid-entry.
    cyc(0, 1, 0, 0, 0, 0);
    key(5); key(6);
    cyc(1, 0, 0, 0, 0, 0);
    check("midreset.pin", pin_input, 16'h0000);

    // Randomised run against the model.
    for (int n = 0; n < 3000; n++) begin
      bit rst, ss, kv, clr, ent;
      int kd;
      rst = ($urandom_range(0, 199) == 0);
      ss  = ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 29) == 0);
      ent = ($urandom_range(0, 7) == 0);
      kv  = ($urandom_range(0, 1) == 0);
      if (m_digs.size() < DIGITS && $urandom_range(0, 9) < 7)
        kd = int'(stored_pin >> (4 * (DIGITS - 1 - m_digs.size()))) & 15;
      else
        kd = int'($urandom_range(0, 11));
      if ($urandom_range(0, 149) == 0) begin
        for (int k = 0; k < 34; k++) idle1();
      end
      cyc(rst, ss, kv, kd, clr, ent);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

Keypad PIN-entry and verification stage that sits directly upstream of `atm_fsm`. It assembles four BCD keypad digits into a 16-bit PIN and compares it against the account PIN. It produces the `pin_input` value and the single-cycle `correct_pin` strobe that `atm_fsm` consumes. It also counts failed attempts, enforces a lockout after `MAX_TRIES` failures, and ends an idle entry session on timeout.

## Interface
Parameters:
- `DIGITS`, 4: PIN length in BCD digits. `pin_input` width is 4*DIGITS.
- `MAX_TRIES`, 3: failed attempts allowed before lockout.
- `TIMEOUT_CYC`, 30: idle cycles in COLLECT before the session is abandoned.

Ports:
- `clk`  in  1  system clock. Single clock domain; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `session_start`  in  1  pulse; a card has been inserted; opens a session.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4  BCD digit, 0-9.
- `key_clear`  in  1  strobe; discard the digits entered so far.
- `key_enter`  in  1  strobe; submit the current entry.
- `stored_pin`  in  16  account PIN, BCD, most significant digit is entered first. Stable for the whole session.
- `pin_input`  out  16  assembled entry; feeds `atm_fsm.pin_input`.
- `correct_pin`  out  1  one-cycle pulse on a match; feeds `atm_fsm.correct_pin`.
- `wrong_pin`  out  1  one-cycle pulse on a mismatch or a short entry.
- `timeout`  out  1  one-cycle pulse when the session is abandoned.
- `attempts`  out  2  failed-attempt count for the current session.
- `lockout`  out  1  level signal; card retained; cleared only by `reset`.
- `busy`  out  1  high in COLLECT and CHECK.

## Operation
States:
- IDLE: waits for `session_start`.
- COLLECT: accepts keys.
- CHECK: one-cycle compare.
- LOCKED: absorbing state.

Transitions:
- IDLE to COLLECT on `session_start`. This clears `attempts`, the digit count and `pin_input`.
- COLLECT, `key_valid` with `key_digit` in 0-9 and digit count < DIGITS:
  - `pin_input <= {pin_input[11:0], key_digit}` and the count increments.
  - If the count is 0, `pin_input` loads `{12'h000, key_digit}` instead.
- COLLECT, ignored keys: a digit greater than 9, or any digit once DIGITS digits are held. An ignored key does not restart the timeout.
- COLLECT, `key_clear`: `pin_input` and the count go to 0; the state stays COLLECT.
- COLLECT to CHECK on `key_enter`, regardless of the digit count.
- CHECK, pass: the count equals DIGITS and `pin_input == stored_pin`. Pulse `correct_pin` and go to IDLE.
- CHECK, fail with `attempts+1 < MAX_TRIES`: pulse `wrong_pin`, increment `attempts`, go to COLLECT.
- CHECK, fail with `attempts+1 == MAX_TRIES`: pulse `wrong_pin`, increment `attempts`, assert `lockout`, go to LOCKED.
- Leaving CHECK: the digit count goes to 0. `pin_input` keeps the checked value until the first digit of the next attempt is accepted or a new session starts.
- COLLECT timeout: TIMEOUT_CYC consecutive cycles with no accepted digit, clear or enter. Pulse `timeout` and go to IDLE. `attempts` does not change.
- LOCKED: all inputs are ignored except `reset`.

Same-cycle priority: `reset` > `session_start` > `key_clear` > `key_enter` > `key_valid`.
- `session_start` in COLLECT restarts the session (full clear).
- `session_start` in CHECK or LOCKED is ignored.

## Timing
- Reset values: state IDLE; `pin_input` 0; `attempts` 0; `correct_pin`, `wrong_pin`, `timeout`, `lockout` and `busy` all 0.
- Reset mid-session: the block returns to IDLE at the next edge and all outputs take their reset values.
- Key acceptance: `pin_input` updates at the edge that samples `key_valid`. A digit key can be accepted every cycle.
- Verdict latency: `key_enter` is sampled at edge k, the state is CHECK after edge k, and `correct_pin`/`wrong_pin` are high from edge k+1 to edge k+2.
- During the verdict pulse, `pin_input` equals the checked value.
- `lockout` rises at the same edge as the final `wrong_pin`.
- Timeout counter: reloaded on entering COLLECT and on every accepted digit, clear or enter. `timeout` is pulsed at the edge where TIMEOUT_CYC idle cycles have elapsed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `atm_pkg` holds:
  - the state encoding (IDLE=0, COLLECT=1, CHECK=2, LOCKED=3);
  - the BCD digit width (4);
  - the PIN width (16);
  - the default MAX_TRIES.
- One sub-module, `atm_idle_timer`: a loadable down-counter with inputs `clk`, `reset`, `restart`, `run` and output `expired`, parameterised by TIMEOUT_CYC.
- The parent holds the FSM, the PIN shift register, the digit counter and the attempt counter.

## Test plan
- Correct PIN: `stored_pin`=16'h1234, keys 1,2,3,4, enter. Expect `correct_pin` high for one cycle, two edges after enter; `pin_input`=16'h1234; `attempts`=0; state returns to IDLE.
- Clear and overflow: keys 9,9, clear, then 1,2,3,4,5, enter. Expect `pin_input`=16'h1234 (the fifth digit is ignored) and `correct_pin` pulses. Also send a `key_digit` of 4'hA and check it is ignored.
- Lockout: three entries of 16'h0000 against 16'h1234. Expect three `wrong_pin` pulses with `attempts` going 1, 2, 3; `lockout` rises with the third pulse. A later `session_start` and correct PIN produce nothing until `reset`.
- Short entry: keys 1,2, enter. Expect `wrong_pin`, `attempts`=1, state COLLECT. A following full correct entry gives `correct_pin`.
- Timeout: `session_start`, key 1, then 30 idle cycles. Expect a `timeout` pulse, state IDLE, `attempts` unchanged.
- Reset mid-entry, and `session_start` coinciding with `key_valid` in COLLECT: all outputs return to their reset values, and the session restarts without the digit being captured.
